// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO. Frames are sent LSB-first:
// start, 5..MAX_DATA_BITS data bits, optional parity, 1 or 2 stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | odd/even parity over the sent bits
// STOP1  | first stop bit
// STOP2  | optional second stop bit
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [MAX_DATA_BITS-1:0]        in_data,
  output logic                            in_ready,
  input  logic [1:0]                      data_bits,
  input  logic [1:0]                      par_mode,
  input  logic                            two_stop,
  output logic                            dout,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(MAX_DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [AW:0]              level;
  logic                     push, pop;

  logic [2:0]               state;
  logic [CW-1:0]            cnt;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic [IW-1:0]            idx;
  logic                     par_acc;
  logic [1:0]               dbits_q, pmode_q;
  logic                     two_q;
  logic                     dout_q, busy_q, done_q;

  logic                     bit_end, last_stop, frame_end, have_data;
  logic                     par_en, data_par, par_bit;
  logic [IW-1:0]            nlast;

  assign in_ready   = (level != (AW+1)'(FIFO_DEPTH));
  assign fifo_level = level;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

  assign push      = in_valid && in_ready;
  assign have_data = (level != '0);
  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign last_stop = (state == STOP2) || (state == STOP1 && !two_q);
  assign frame_end = last_stop && bit_end;
  assign pop       = have_data && ((state == IDLE) || frame_end);
  assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign nlast     = IW'(MAX_DATA_BITS - 4) + IW'(dbits_q);
  // Parity includes the bit currently on the line, which is the last data bit.
  assign data_par  = par_acc ^ shreg[0];
  assign par_bit   = (pmode_q == 2'b01) ? ~data_par : data_par;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      idx     <= '0;
      par_acc <= 1'b0;
      dbits_q <= 2'b00;
      pmode_q <= 2'b00;
      two_q   <= 1'b0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Registered so the pulse lines up with the final stop-bit clock.
      done_q <= last_stop && (cnt == CW'(CLKS_PER_BIT - 2));
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;

      if (pop) begin
        shreg   <= mem[rptr];
        dbits_q <= data_bits;
        pmode_q <= par_mode;
        two_q   <= two_stop;
        state   <= START;
        dout_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else if (frame_end) begin
        state  <= IDLE;
        dout_q <= 1'b1;
        busy_q <= 1'b0;
      end else if (bit_end) begin
        case (state)
          START: begin
            state   <= DATA;
            idx     <= '0;
            par_acc <= 1'b0;
            dout_q  <= shreg[0];
          end
          DATA: begin
            shreg   <= shreg >> 1;
            idx     <= idx + 1'b1;
            par_acc <= data_par;
            if (idx == nlast) begin
              state  <= par_en ? PARITY : STOP1;
              dout_q <= par_en ? par_bit : 1'b1;
            end else begin
              dout_q <= shreg[1];
            end
          end
          PARITY: begin
            state  <= STOP1;
            dout_q <= 1'b1;
          end
          STOP1: begin
            state  <= STOP2;
            dout_q <= 1'b1;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a
// monitor decodes dout cycle by cycle and compares against the queue.
module tb_uart_tx_fifo;
  localparam int C = 4;
  localparam int M = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] data_bits;
  logic [1:0] par_mode;
  logic       two_stop;
  logic       dout, busy, tx_done;
  logic [2:0] fifo_level;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .MAX_DATA_BITS(M), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_bits(data_bits), .par_mode(par_mode),
    .two_stop(two_stop), .dout(dout), .busy(busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  logic   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame bit list; pbit is the hand-computed parity value.
  function automatic frame_t mk(input logic [7:0] d, input logic [1:0] code,
                                input logic [1:0] pm, input logic two, input logic pbit);
    frame_t f;
    int n, p;
    n = 5 + int'(code);
    f.bits = '1;
    f.bits[0] = 1'b0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      f.bits[p] = d[i];
      p++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      f.bits[p] = pbit;
      p++;
    end
    f.len = p + (two ? 2 : 1);
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < limit) begin
      @(posedge clk);
      t++;
    end
    check("drain_in_time", {31'b0, (t < limit)}, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  // Monitor
  frame_t cur;
  int     nfr = 0;
  logic   ok, aborted, early, last_td;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dout === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: dout low with no frame expected");
          for (int w = 0; w < 1000 && !rst && busy; w++) @(negedge clk);
        end else begin
          cur = exp_q.pop_front();
          aborted = 1'b0;
          early = 1'b0;
          last_td = 1'b0;
          for (int k = 0; k < cur.len && !aborted; k++) begin
            ok = 1'b1;
            for (int c = 0; c < C && !aborted; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (rst) aborted = 1'b1;
              else begin
                if (dout !== cur.bits[k]) ok = 1'b0;
                if (k == cur.len - 1 && c == C - 1) last_td = tx_done;
                else if (tx_done) early = 1'b1;
              end
            end
            if (!aborted)
              check($sformatf("frame%0d_bit%0d_ok", nfr, k), {31'b0, ok}, 32'd1);
          end
          if (!aborted)
            check($sformatf("frame%0d_tx_done_pos", nfr), {30'b0, last_td, early}, 32'd2);
          nfr++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int gaps, lows;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    data_bits = 2'b11; par_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {31'b0, dout}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_tx_done", {31'b0, tx_done}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_fifo_level", {29'b0, fifo_level}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 0x55 with exact timing
    exp_q.push_back(mk(8'h55, 2'b11, 2'b00, 1'b0, 1'b0));
    send(8'h55);
    @(posedge clk); #1;
    check("t1_start_dout", {31'b0, dout}, 32'd0);
    check("t1_start_busy", {31'b0, busy}, 32'd1);
    repeat (39) @(posedge clk);
    #1;
    check("t1_tx_done_clk40", {31'b0, tx_done}, 32'd1);
    @(posedge clk); #1;
    check("t1_busy_clk41", {31'b0, busy}, 32'd0);
    check("t1_dout_clk41", {31'b0, dout}, 32'd1);
    drain(100);

    // 0xA3 has four ones: even parity 0, odd parity 1
    par_mode = 2'b10;
    exp_q.push_back(mk(8'hA3, 2'b11, 2'b10, 1'b0, 1'b0));
    send(8'hA3);
    drain(100);
    par_mode = 2'b01;
    exp_q.push_back(mk(8'hA3, 2'b11, 2'b01, 1'b0, 1'b1));
    send(8'hA3);
    drain(100);

    // 5 bits, 2 stop bits, upper bits of 0xFF dropped
    par_mode = 2'b00; data_bits = 2'b00; two_stop = 1'b1;
    exp_q.push_back(mk(8'hFF, 2'b00, 2'b00, 1'b1, 1'b0));
    send(8'hFF);
    drain(100);
    data_bits = 2'b11; two_stop = 1'b0;

    // back-to-back, FIFO fill, refused sixth write
    gaps = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i * 17);
      if (i < 5) exp_q.push_back(mk(8'h10 + 8'(i * 17), 2'b11, 2'b00, 1'b0, 1'b0));
      @(posedge clk); #1;
      if (i >= 1 && !busy) gaps++;
      if (i == 4) begin
        check("t4_level_full", {29'b0, fifo_level}, 32'd4);
        check("t4_in_ready_full", {31'b0, in_ready}, 32'd0);
      end
      if (i == 5) check("t4_level_after_refused", {29'b0, fifo_level}, 32'd4);
    end
    in_valid = 1'b0;
    repeat (195) begin
      @(posedge clk); #1;
      if (!busy) gaps++;
    end
    check("t4_busy_gaps", gaps, 32'd0);
    @(posedge clk); #1;
    check("t4_busy_end", {31'b0, busy}, 32'd0);
    drain(100);

    // config change mid-frame: 0x07 has three ones, even parity 1
    exp_q.push_back(mk(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h07, 2'b11, 2'b10, 1'b0, 1'b1));
    send(8'h3C);
    send(8'h07);
    repeat (10) @(posedge clk);
    par_mode = 2'b10;
    drain(300);
    par_mode = 2'b00;

    // reset during a zero data bit of 0x0F
    exp_q.push_back(mk(8'h0F, 2'b11, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h33, 2'b11, 2'b00, 1'b0, 1'b0));
    send(8'h0F);
    send(8'h33);
    repeat (21) @(posedge clk);
    #1;
    check("t6_dout_low_before_rst", {31'b0, dout}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_dout", {31'b0, dout}, 32'd1);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_level", {29'b0, fifo_level}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (!dout || busy || fifo_level != 0) lows++;
    end
    check("t6_no_residual_frame", lows, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
